regfile_dump: RTL and testbench
===============================

// Module: regfile_dump
// PURPOSE
//  Debug read-out engine for the integer register file: on a start pulse it drives the
//  regfile read port through x0..x(NUM_REGS-1) and streams each value on a valid/ready
//  output. Reads through a spare read port (read_reg2/read_data2) while the core is halted.
//  Used by the debug path and by benches to snapshot architectural state.
// PARAMETERS
//  NUM_REGS  32  registers dumped, indices 0..NUM_REGS-1 (power of two, 2..32)
//  DATA_W    32  register data width
//  ADDR_W    5   regfile address width, $clog2(NUM_REGS)
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rstn       in   1        reset, synchronous, active-low
//  start      in   1        1-cycle request to begin a dump; ignored while busy
//  rd_reg     out  ADDR_W   regfile read address (to read_reg2)
//  rd_data    in   DATA_W   regfile read data (from read_data2), combinational read
//  out_valid  out  1        out_idx/out_data hold a word
//  out_ready  in   1        consumer accepts word when out_valid && out_ready at posedge
//  out_idx    out  ADDR_W+1 register index of word (NUM_REGS = checksum word)
//  out_data   out  DATA_W   register value (signed, passed through unmodified)
//  busy       out  1        high from cycle after accepted start until done
//  done       out  1        1-cycle pulse after final word accepted
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state IDLE, rd_reg=0, out_valid=0, out_idx=0, out_data=0,
//    busy=0, done=0, index counter=0. Reset mid-dump aborts; no further words or done.
//  - FSM: IDLE -start-> READ -> SEND -(accept, idx<last)-> READ; SEND -(accept, last)->
//    [CSUM ->] DONE -> IDLE. DONE lasts exactly one cycle (done=1, busy=0).
//  - READ: rd_reg=counter; at posedge rd_data captured into out_data, out_idx=counter,
//    out_valid=1, state SEND. Each register costs 1 READ cycle + >=1 SEND cycle.
//  - Latency: start sampled at edge k -> busy=1, rd_reg=0 after k; out_valid=1 after k+1.
//  - SEND: out_idx/out_data/out_valid stable while out_valid && !out_ready; on accept
//    counter++ and out_valid drops for the READ cycle (no back-to-back words).
//  - x0 is read like any register (regfile returns 0); no special casing.
//  - Counter is ADDR_W+1 bits; last register is NUM_REGS-1; no wrap to 0 mid-dump.
//  - start while busy or in DONE: ignored, no restart. start in IDLE coincident with
//    reset: reset wins.
//  - rd_reg holds last driven value in IDLE/DONE; consumer must not rely on it.
// CONFIGURATION
//  REGFILE_DUMP_CHECKSUM_EN defined: after register NUM_REGS-1 is accepted, state CSUM
//    presents one extra word out_idx=NUM_REGS, out_data=XOR of all NUM_REGS values sent,
//    same hold/accept rules; done follows its acceptance. Accumulator cleared on start.
//  Undefined: no CSUM state, done follows acceptance of register NUM_REGS-1; exactly
//    NUM_REGS words per dump.
// STRUCTURE
//  regfile_dump_pkg: state enum dump_state_t {IDLE, READ, SEND, CSUM, DONE},
//    localparam IDX_W = ADDR_W+1 helper, CSUM_IDX constant.
//  Single module; checksum XOR accumulator kept inline under the macro, no sub-module.
//  Bench instantiates regfile + regfile_dump, writes via regfile write port first.
// TESTING
//  1 Write x10=12983, x30=324, others 0; start, out_ready=1 -> 32 words, idx 0..31,
//    word10=12983, word30=324, word0=0, done pulse once, busy low after.
//  2 out_ready low 3 cycles on word 10 -> out_data=12983/out_idx=10 held stable, no skip.
//  3 start pulsed again at word 5 -> ignored; dump still ends at idx 31, single done.
//  4 rstn=0 during word 17 SEND -> next cycle out_valid=0, busy=0; no done; new start
//    restarts from idx 0.
//  5 x5=-1 (32'hFFFFFFFF), x6=500 -> words 5/6 exactly -1/500 (signed preserved).
//  6 CHECKSUM_EN, only x10=12983, x30=324 -> word idx 32 = 12983^324 (32'h000033F3).

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and default geometry for the register-file dump engine.
// The checksum word is enabled with REGFILE_DUMP_CHECKSUM_EN.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;

  // Index counter is one bit wider than the address so it can name the checksum word.
  localparam int unsigned IDX_W    = ADDR_W_DEF + 1;
  localparam int unsigned CSUM_IDX = NUM_REGS_DEF;

  function automatic int unsigned idx_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the spare regfile read port over x0..x(NUM_REGS-1)
// and streams each value on a valid/ready port. REGFILE_DUMP_CHECKSUM_EN adds an XOR word.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    CNT_W     = idx_width(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CSUM_WORD = CNT_W'(NUM_REGS);

  dump_state_t      state;
  dump_state_t      state_next;
  logic [CNT_W-1:0] cnt;

  // The counter's low bits address the regfile directly; its top bit never reaches rd_reg.
  assign rd_reg = cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt != LAST_IDX) begin
            state_next = READ;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
      CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (state == SEND && out_ready) begin
      csum <= csum ^ out_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      out_idx  <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) cnt <= '0;
        end
        READ: begin
          out_data <= rd_data;
          out_idx  <= cnt;
        end
        SEND: begin
          if (out_ready) begin
            cnt <= cnt + CNT_W'(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Fold the word being accepted now; csum only catches up on this same edge.
            if (cnt == LAST_IDX) begin
              out_idx  <= CSUM_WORD;
              out_data <= csum ^ out_data;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural regfile on the spare read port.
// Honours REGFILE_DUMP_CHECKSUM_EN for the extra checksum word.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NW = NR + 1;
`else
  localparam int NW = NR;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             out_ready;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rd_reg;
  logic [DW-1:0]    rd_data;
  logic [DW-1:0]    out_data;
  logic [IDX_W-1:0] out_idx;

  logic [DW-1:0] regs [NR];
  assign rd_data = regs[rd_reg];

  regfile_dump #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rd_reg(rd_reg), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tid;
    int          idx;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] got_data [64];
  int          got_idx [64];
  int          got_n;
  int          done_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < NR; i++) regs[i] = '0;
  endtask

  task automatic run_dump(input string tag, input int stall_idx, input int stall_n,
                          input int restart_idx, input int rst_idx);
    int stalled  = 0;
    int gap_err  = 0;
    bit fin      = 0;
    bit prev_acc = 0;
    bit seq_ok   = 1;
    got_n  = 0;
    done_n = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_lat_busy"}, 64'(busy), 64'(1));
    chk({tag, "_lat_rdreg"}, 64'(rd_reg), 64'(0));
    chk({tag, "_lat_novalid"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_lat_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_lat_idx0"}, 64'(out_idx), 64'(0));
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      out_ready = 1'b1;
      start = 1'b0;
      if (done) begin
        done_n++;
        fin = 1;
        chk({tag, "_done_busy"}, 64'(busy), 64'(0));
      end else if (out_valid) begin
        if (prev_acc) gap_err++;
        prev_acc = 0;
        if (rst_idx >= 0 && int'(out_idx) == rst_idx) begin
          rstn = 1'b0;
          out_ready = 1'b0;
          @(posedge clk); #1;
          rstn = 1'b1;
          chk({tag, "_rst_valid"}, 64'(out_valid), 64'(0));
          chk({tag, "_rst_busy"}, 64'(busy), 64'(0));
          repeat (8) begin
            @(posedge clk); #1;
            if (done || out_valid) done_n++;
          end
          chk({tag, "_rst_quiet"}, 64'(done_n), 64'(0));
          return;
        end
        if (int'(out_idx) == stall_idx && stalled < stall_n) begin
          out_ready = 1'b0;
          chk({tag, "_hold_idx"}, 64'(out_idx), 64'(stall_idx));
          chk({tag, "_hold_data"}, 64'(out_data), 64'(regs[stall_idx]));
          stalled++;
        end else begin
          if (got_n < 64) begin
            got_idx[got_n]  = int'(out_idx);
            got_data[got_n] = out_data;
            got_n++;
          end
          prev_acc = 1;
          if (restart_idx >= 0 && int'(out_idx) == restart_idx) start = 1'b1;
        end
      end else begin
        prev_acc = 0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 64'(fin), 64'(1));
    repeat (5) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    chk({tag, "_done_once"}, 64'(done_n), 64'(1));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    chk({tag, "_words"}, 64'(got_n), 64'(NW));
    chk({tag, "_gap"}, 64'(gap_err), 64'(0));
    for (int i = 0; i < got_n; i++) if (got_idx[i] != i) seq_ok = 0;
    chk({tag, "_seq"}, 64'(seq_ok), 64'(1));
  endtask

  task automatic check_words(input int tid);
    foreach (vecs[i]) begin
      if (vecs[i].tid == tid) begin
        if (vecs[i].idx < got_n) begin
          chk($sformatf("t%0d_word%0d", tid, vecs[i].idx), 64'(got_data[vecs[i].idx]),
              64'(vecs[i].data));
        end else begin
          chk($sformatf("t%0d_word%0d_missing", tid, vecs[i].idx), 64'(got_n),
              64'(vecs[i].idx + 1));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{1, 0,  32'd0});
    vecs.push_back('{1, 10, 32'd12983});
    vecs.push_back('{1, 30, 32'd324});
    vecs.push_back('{1, 31, 32'd0});
    vecs.push_back('{2, 10, 32'd12983});
    vecs.push_back('{2, 11, 32'd0});
    vecs.push_back('{3, 30, 32'd324});
    vecs.push_back('{3, 31, 32'd0});
    vecs.push_back('{5, 5,  32'hFFFF_FFFF});
    vecs.push_back('{5, 6,  32'd500});
    vecs.push_back('{5, 10, 32'd0});
`ifdef REGFILE_DUMP_CHECKSUM_EN
    vecs.push_back('{1, CSUM_IDX, 32'h0000_33F3});
    vecs.push_back('{5, CSUM_IDX, 32'hFFFF_FE0B});
`endif

    clear_regs();
    rstn = 1'b0;
    start = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_rdreg", 64'(rd_reg), 64'(0));
    rstn = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'(0));

    regs[10] = 32'd12983;
    regs[30] = 32'd324;
    run_dump("t1", -1, 0, -1, -1);
    check_words(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("t1_csum_idx", 64'(got_idx[NW-1]), 64'(CSUM_IDX));
`endif

    run_dump("t2", 10, 3, -1, -1);
    check_words(2);

    run_dump("t3", -1, 0, 5, -1);
    check_words(3);

    run_dump("t4", -1, 0, -1, 17);
    run_dump("t4b", -1, 0, -1, -1);
    check_words(1);

    clear_regs();
    regs[5] = 32'hFFFF_FFFF;
    regs[6] = 32'd500;
    run_dump("t5", -1, 0, -1, -1);
    check_words(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
